reg_bank_4x: RTL
================

// Module: reg_bank_4x
// PURPOSE
//  Four-entry register bank that consumes the one-hot reg0WE..reg3WE strobes
//  produced by the write-enable decoder. Write data comes from the ALU result bus.
//  Two read ports are registered and feed the ALU operand inputs.
//  Read ports have write-through bypass, so a same-cycle write is visible at the next edge.
//  A sticky fault flag records illegal multi-hot write enables.
// PARAMETERS
//  DATA_WIDTH   8      width of each register and of all data ports
//  RESET_VALUE  8'h00  value loaded into every register on reset (DATA_WIDTH wide)
// PORTS
//  logisimClockTree0  in   5           clock tree; [4] = global clock, [2] = rising-edge tick enable
//  reset              in   1           synchronous, active-high
//  reg0WE..reg3WE     in   1 each      one-hot write strobes from decoder
//  writeData          in   DATA_WIDTH  value written to the selected register
//  RsA                in   2           read address, port A
//  RsB                in   2           read address, port B
//  rdDataA            out  DATA_WIDTH  registered read data, port A
//  rdDataB            out  DATA_WIDTH  registered read data, port B
//  reg0..reg3         out  DATA_WIDTH  direct register contents, for debug/probe
//  weFault            out  1           sticky: more than one WE was seen high on a tick
// BEHAVIOUR
//  - Clocking
//    - All state updates on the rising edge of logisimClockTree0[4].
//    - State changes only when logisimClockTree0[2]=1 (tick).
//    - reset is honoured on any rising edge, tick or not.
//  - Reset
//    - reg0..reg3 = RESET_VALUE; rdDataA = rdDataB = RESET_VALUE; weFault = 0.
//    - Reset dominates every WE.
//    - A write pending in the reset cycle is dropped.
//  - Write
//    - On a tick with exactly one regNWE=1, regN <= writeData.
//    - With all WEs low, nothing changes.
//  - Multi-hot WE (two or more high on a tick)
//    - No register is written.
//    - weFault <= 1 and stays 1 until reset.
//  - Read
//    - On each tick, rdDataA <= value(RsA) and rdDataB <= value(RsB).
//    - value(x) is writeData if register x is being written this tick, else regX (bypass).
//    - Latency is 1 tick from address to data.
//    - Bypass is not applied when the write is suppressed by a multi-hot WE.
//  - Both read ports may address the same register, including one being written.
//    Both then return identical data.
//  - Without a tick, rdDataA/B hold their values; address changes have no effect.
//  - reg0..reg3 outputs are the flop contents: written values appear 1 tick after the write.
//  - Width rules: no arithmetic. All data paths are DATA_WIDTH with no truncation or extension.
// STRUCTURE
//  - Shared package holds:
//    - DATA_WIDTH default
//    - REG_COUNT = 4
//    - REG_ADDR_W = 2
//    - helper onehot_valid(we[3:0]): returns 1 for zero or one bits set
//  - One sub-module, reg_bank_read_port, instantiated twice.
//    - Inputs: addr, the 4 register values, the 4 gated WEs, writeData.
//    - Implements the bypass mux and the output flop.
//  - Top level holds the 4 data flops, WE gating (suppressed when multi-hot) and the weFault flop.
// TESTING
//  1. Reset with WE/addr randomised -> reg0..3 = 00, rdDataA/B = 00, weFault = 0 after 1 edge.
//  2. Sequential writes, with A reading each register in turn 2 ticks later -> rdDataA = 11,22,33,44.
//     - Writes: reg0WE + 8'h11, reg1WE + 8'h22, reg2WE + 8'h33, reg3WE + 8'h44, one per tick.
//  3. Bypass: reg2 = 33, then reg2WE + writeData = 8'hA5 with RsA = RsB = 2 on the same tick
//     -> rdDataA = rdDataB = A5 next tick, and reg2 = A5.
//  4. Multi-hot: reg1WE = reg3WE = 1, writeData = 8'hFF
//     -> reg1 and reg3 unchanged, bypass not applied, weFault = 1.
//     - weFault stays 1 over 10 idle ticks; clears only on reset.
//  5. Tick gating: clock edges with logisimClockTree0[2] = 0, reg0WE = 1, data 8'h5A
//     -> no register or read output changes; first ticked edge writes 5A.
//  6. Reset mid-op: reset = 1 on the same edge as reg3WE = 1, writeData = 8'h77
//     -> reg3 = 00, rdDataA/B = 00, weFault = 0.

Source files
------------

// File: rtl/reg_bank_4x_pkg.sv
// Shared sizing constants and helpers for the four-entry register bank.
// Imported by the bank top level and by its read-port slices.
package reg_bank_4x_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int REG_COUNT          = 4;
    localparam int REG_ADDR_W         = 2;

    typedef logic [REG_COUNT-1:0]  we_vec_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // A write-enable vector is legal when no more than one strobe is raised.
    function automatic logic onehot_valid(input we_vec_t we);
        return ($countones(we) <= 1);
    endfunction

endpackage : reg_bank_4x_pkg

// File: rtl/reg_bank_read_port.sv
// One registered read port with write-through bypass.
// The bypass mux forwards the incoming write data when the addressed register is written this tick.
module reg_bank_read_port
    import reg_bank_4x_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                 clk,
    input  logic                                 i_reset,
    input  logic                                 i_tick,
    input  reg_addr_t                            i_addr,
    input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] i_regs,
    input  we_vec_t                              i_we,
    input  logic [DATA_WIDTH-1:0]                i_write_data,
    output logic [DATA_WIDTH-1:0]                o_rd_data
);

    logic [DATA_WIDTH-1:0] w_value;
    logic [DATA_WIDTH-1:0] r_rd_data;

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        w_value = i_regs[i_addr];
        if (i_we[i_addr]) begin
            w_value = i_write_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_rd_data <= RESET_VALUE;
        end else if (i_tick) begin
            r_rd_data <= w_value;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : reg_bank_read_port

// File: rtl/reg_bank_4x.sv
// Four-entry register bank fed by one-hot decoder strobes, with two bypassed registered
// read ports and a sticky flag that records illegal multi-hot write enables.
module reg_bank_4x
    import reg_bank_4x_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [4:0]            logisimClockTree0,
    input  logic                  reset,
    input  logic                  reg0WE,
    input  logic                  reg1WE,
    input  logic                  reg2WE,
    input  logic                  reg3WE,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  reg_addr_t             RsA,
    input  reg_addr_t             RsB,
    output logic [DATA_WIDTH-1:0] rdDataA,
    output logic [DATA_WIDTH-1:0] rdDataB,
    output logic [DATA_WIDTH-1:0] reg0,
    output logic [DATA_WIDTH-1:0] reg1,
    output logic [DATA_WIDTH-1:0] reg2,
    output logic [DATA_WIDTH-1:0] reg3,
    output logic                  weFault
);

    logic    w_clk;
    logic    w_tick;
    logic    w_unused_clk_bits;
    we_vec_t w_we_raw;
    logic    w_we_legal;
    we_vec_t w_we_gated;

    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] r_regs;
    logic                                 r_we_fault;

    assign w_clk             = logisimClockTree0[4];
    assign w_tick            = logisimClockTree0[2];
    assign w_unused_clk_bits = ^{logisimClockTree0[3], logisimClockTree0[1:0]};

    // A multi-hot strobe set is dropped entirely, which also disables the read bypass.
    assign w_we_raw   = {reg3WE, reg2WE, reg1WE, reg0WE};
    assign w_we_legal = onehot_valid(w_we_raw);
    assign w_we_gated = w_we_legal ? w_we_raw : '0;

    // NOTE: the register file is reset explicitly because software reads it straight after reset.
    always_ff @(posedge w_clk) begin
        if (reset) begin
            r_regs     <= {REG_COUNT{RESET_VALUE}};
            r_we_fault <= 1'b0;
        end else if (w_tick) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (w_we_gated[i]) begin
                    r_regs[i] <= writeData;
                end
            end
            if (!w_we_legal) begin
                r_we_fault <= 1'b1;
            end
        end
    end

    reg_bank_read_port #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_read_a (
        .clk          (w_clk),
        .i_reset      (reset),
        .i_tick       (w_tick),
        .i_addr       (RsA),
        .i_regs       (r_regs),
        .i_we         (w_we_gated),
        .i_write_data (writeData),
        .o_rd_data    (rdDataA)
    );

    reg_bank_read_port #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_read_b (
        .clk          (w_clk),
        .i_reset      (reset),
        .i_tick       (w_tick),
        .i_addr       (RsB),
        .i_regs       (r_regs),
        .i_we         (w_we_gated),
        .i_write_data (writeData),
        .o_rd_data    (rdDataB)
    );

    assign reg0    = r_regs[0];
    assign reg1    = r_regs[1];
    assign reg2    = r_regs[2];
    assign reg3    = r_regs[3];
    assign weFault = r_we_fault;

endmodule : reg_bank_4x
